// File: rtl/iob_cache_ctrl_seq.sv
// Cache-control sequencer: drains the write-through buffer, invalidates the cache and,
// when IOB_CACHE_CTRL_SEQ_CNT_EN is defined, snapshots (and optionally clears) hit/miss counters.

`ifndef IOB_CACHE_CSRS_ADDR_W
`define IOB_CACHE_CSRS_ADDR_W 4
`endif
`ifndef IOB_CACHE_WTB_EMPTY_ADDR
`define IOB_CACHE_WTB_EMPTY_ADDR 4
`endif
`ifndef IOB_CACHE_RW_HIT_ADDR
`define IOB_CACHE_RW_HIT_ADDR 12
`endif
`ifndef IOB_CACHE_RW_MISS_ADDR
`define IOB_CACHE_RW_MISS_ADDR 16
`endif
`ifndef IOB_CACHE_RST_CNTRS_ADDR
`define IOB_CACHE_RST_CNTRS_ADDR 20
`endif
`ifndef IOB_CACHE_INVALIDATE_ADDR
`define IOB_CACHE_INVALIDATE_ADDR 24
`endif

module iob_cache_ctrl_seq #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = `IOB_CACHE_CSRS_ADDR_W,
    parameter int POLL_MAX = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              clr_cnt_i,
    output logic              ctrl_valid_o,
    output logic [ADDR_W-1:0] ctrl_addr_o,
    input  logic              ctrl_ready_i,
    input  logic [DATA_W-1:0] ctrl_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] hit_cnt_o,
    output logic [DATA_W-1:0] miss_cnt_o
);

    localparam int                POLL_W   = $clog2(POLL_MAX + 1);
    localparam logic [POLL_W-1:0] POLL_TOP = POLL_W'(POLL_MAX);

    localparam logic [ADDR_W-1:0] A_WTB = ADDR_W'(`IOB_CACHE_WTB_EMPTY_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_INV = ADDR_W'(`IOB_CACHE_INVALIDATE_ADDR >> 2);
`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
    localparam logic [ADDR_W-1:0] A_HIT  = ADDR_W'(`IOB_CACHE_RW_HIT_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_MISS = ADDR_W'(`IOB_CACHE_RW_MISS_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_RST  = ADDR_W'(`IOB_CACHE_RST_CNTRS_ADDR >> 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_INV,
        S_RD_HIT,
        S_RD_MISS,
        S_RST_CNT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pend;
    logic              acked;
    logic [POLL_W-1:0] poll_cnt;
    logic [POLL_W-1:0] poll_inc;
    logic              poll_timeout;

    // pend marks the single outstanding access; ready is only honoured while it is set
    assign acked        = pend && ctrl_ready_i;
    assign poll_inc     = (poll_cnt == POLL_TOP) ? poll_cnt : poll_cnt + 1'b1;
    assign poll_timeout = (poll_inc == POLL_TOP);

`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
    logic clr_lat;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (acked) begin
                    if (ctrl_rdata_i[0]) state_nxt = S_INV;
                    else if (poll_timeout) state_nxt = S_DONE;
                end
            end
            S_INV: begin
`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
                if (acked) state_nxt = S_RD_HIT;
`else
                if (acked) state_nxt = S_DONE;
`endif
            end
`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
            S_RD_HIT: begin
                if (acked) state_nxt = S_RD_MISS;
            end
            S_RD_MISS: begin
                if (acked) state_nxt = clr_lat ? S_RST_CNT : S_DONE;
            end
            S_RST_CNT: begin
                if (acked) state_nxt = S_DONE;
            end
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_valid_o = 1'b0;
        ctrl_addr_o  = '0;
        busy_o       = (state != S_IDLE);
        done_o       = (state == S_DONE);
        if (!pend) begin
            case (state)
                S_DRAIN: begin
                    ctrl_valid_o = 1'b1;
                    ctrl_addr_o  = A_WTB;
                end
                S_INV: begin
                    ctrl_valid_o = 1'b1;
                    ctrl_addr_o  = A_INV;
                end
`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
                S_RD_HIT: begin
                    ctrl_valid_o = 1'b1;
                    ctrl_addr_o  = A_HIT;
                end
                S_RD_MISS: begin
                    ctrl_valid_o = 1'b1;
                    ctrl_addr_o  = A_MISS;
                end
                S_RST_CNT: begin
                    ctrl_valid_o = 1'b1;
                    ctrl_addr_o  = A_RST;
                end
`endif
                default: begin
                    ctrl_valid_o = 1'b0;
                    ctrl_addr_o  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend     <= 1'b0;
            poll_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if (ctrl_valid_o) pend <= 1'b1;
            else if (acked) pend <= 1'b0;

            if (state == S_IDLE && start_i) begin
                err_o    <= 1'b0;
                poll_cnt <= '0;
            end else if (state == S_DRAIN && acked && !ctrl_rdata_i[0]) begin
                poll_cnt <= poll_inc;
                if (poll_timeout) err_o <= 1'b1;
            end
        end
    end

`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clr_lat    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (state == S_IDLE && start_i) clr_lat <= clr_cnt_i;
            if (state == S_RD_HIT && acked) hit_cnt_o <= ctrl_rdata_i;
            if (state == S_RD_MISS && acked) miss_cnt_o <= ctrl_rdata_i;
        end
    end
`else
    // Without the counter feature only the drain status bit of the read data matters
    logic unused_in;
    assign unused_in  = ^{clr_cnt_i, ctrl_rdata_i[DATA_W-1:1]};
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_iob_cache_ctrl_seq.sv
// Randomized bench for iob_cache_ctrl_seq: a responder plus a sequence-level reference model
// that predicts the access list, err_o and counter snapshots of every flush.

`ifndef IOB_CACHE_CSRS_ADDR_W
`define IOB_CACHE_CSRS_ADDR_W 4
`endif
`ifndef IOB_CACHE_WTB_EMPTY_ADDR
`define IOB_CACHE_WTB_EMPTY_ADDR 4
`endif
`ifndef IOB_CACHE_RW_HIT_ADDR
`define IOB_CACHE_RW_HIT_ADDR 12
`endif
`ifndef IOB_CACHE_RW_MISS_ADDR
`define IOB_CACHE_RW_MISS_ADDR 16
`endif
`ifndef IOB_CACHE_RST_CNTRS_ADDR
`define IOB_CACHE_RST_CNTRS_ADDR 20
`endif
`ifndef IOB_CACHE_INVALIDATE_ADDR
`define IOB_CACHE_INVALIDATE_ADDR 24
`endif

module tb_iob_cache_ctrl_seq;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = `IOB_CACHE_CSRS_ADDR_W;
    localparam int POLL_MAX = 4;
`ifdef IOB_CACHE_CTRL_SEQ_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] A_WTB  = ADDR_W'(`IOB_CACHE_WTB_EMPTY_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_INV  = ADDR_W'(`IOB_CACHE_INVALIDATE_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_HIT  = ADDR_W'(`IOB_CACHE_RW_HIT_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_MISS = ADDR_W'(`IOB_CACHE_RW_MISS_ADDR >> 2);
    localparam logic [ADDR_W-1:0] A_RST  = ADDR_W'(`IOB_CACHE_RST_CNTRS_ADDR >> 2);

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic              clr_cnt_i;
    logic              ctrl_valid_o;
    logic [ADDR_W-1:0] ctrl_addr_o;
    logic              ctrl_ready_i;
    logic [DATA_W-1:0] ctrl_rdata_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [DATA_W-1:0] hit_cnt_o;
    logic [DATA_W-1:0] miss_cnt_o;

    iob_cache_ctrl_seq #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .POLL_MAX(POLL_MAX)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .clr_cnt_i   (clr_cnt_i),
        .ctrl_valid_o(ctrl_valid_o),
        .ctrl_addr_o (ctrl_addr_o),
        .ctrl_ready_i(ctrl_ready_i),
        .ctrl_rdata_i(ctrl_rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DATA_W-1:0] m_hit;
    logic [DATA_W-1:0] m_miss;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_valid"}, longint'(ctrl_valid_o), 0);
        chk({pfx, "_addr"},  longint'(ctrl_addr_o), 0);
        chk({pfx, "_busy"},  longint'(busy_o), 0);
        chk({pfx, "_done"},  longint'(done_o), 0);
        chk({pfx, "_err"},   longint'(err_o), 0);
        chk({pfx, "_hit"},   longint'(hit_cnt_o), 0);
        chk({pfx, "_miss"},  longint'(miss_cnt_o), 0);
    endtask

    // One flush: nzeros "buffer not empty" replies precede the first "empty" reply.
    task automatic run_seq(input bit clr, input int nzeros, input logic [DATA_W-1:0] hv,
                           input logic [DATA_W-1:0] mv, input bit do_reset, input bit mid_start);
        logic [ADDR_W-1:0] exp_q[$];
        logic [ADDR_W-1:0] obs_q[$];
        bit                drain_q[$];
        logic [ADDR_W-1:0] resp_addr;
        logic [ADDR_W-1:0] trig;
        logic [DATA_W-1:0] r;
        logic              v;
        logic [ADDR_W-1:0] a;
        bit tmo, resp_due, rst_hit;
        int polls, done_cnt, addr_bad, dbl, busy_bad, post, mid_at, v_after, n;

        resp_due = 0; rst_hit = 0;
        done_cnt = 0; addr_bad = 0; dbl = 0; busy_bad = 0; post = 0;
        resp_addr = '0;
        tmo   = (nzeros >= POLL_MAX);
        polls = tmo ? POLL_MAX : nzeros + 1;
        for (int i = 0; i < nzeros; i++) drain_q.push_back(1'b0);
        drain_q.push_back(1'b1);
        for (int i = 0; i < polls; i++) exp_q.push_back(A_WTB);
        if (!tmo) begin
            exp_q.push_back(A_INV);
            if (CNT_EN) begin
                exp_q.push_back(A_HIT);
                exp_q.push_back(A_MISS);
                if (clr) exp_q.push_back(A_RST);
            end
        end
        trig   = CNT_EN ? A_HIT : A_INV;
        mid_at = $urandom_range(2, 4);

        for (int cyc = 0; cyc < 300 && post < 6; cyc++) begin
            @(negedge clk_i);
            if (cyc > 0) begin
                v = ctrl_valid_o;
                a = ctrl_addr_o;
                if (!v && a != '0) addr_bad++;
                if (cyc == 1) chk("busy_after_start", longint'(busy_o), 1);
                if (done_cnt > 0 && busy_o) busy_bad++;
                if (done_o) done_cnt++;
                if (done_cnt > 0) post++;
                if (v) begin
                    if (resp_due) dbl++;
                    obs_q.push_back(a);
                end
                if (do_reset && v && a == trig) begin
                    #1;
                    reset_i = 1'b1;
                    ctrl_ready_i = 1'b0;
                    start_i = 1'b0;
                    #1;
                    check_all_zero("rst_mid");
                    m_hit  = '0;
                    m_miss = '0;
                    rst_hit = 1;
                    repeat (3) @(negedge clk_i);
                    reset_i = 1'b0;
                    v_after = 0;
                    repeat (10) begin
                        @(negedge clk_i);
                        if (ctrl_valid_o) v_after++;
                        if (done_o) done_cnt++;
                    end
                    chk("rst_no_valid", longint'(v_after), 0);
                    chk("rst_no_done", longint'(done_cnt), 0);
                    break;
                end
            end
            start_i   = (cyc == 0) || (mid_start && cyc == mid_at);
            clr_cnt_i = (cyc == 0) ? clr : 1'($urandom_range(0, 1));
            if (resp_due) begin
                r = $urandom;
                if (resp_addr == A_WTB) r[0] = (drain_q.size() > 0) ? drain_q.pop_front() : 1'b0;
                else if (resp_addr == A_HIT) r = hv;
                else if (resp_addr == A_MISS) r = mv;
                ctrl_ready_i = 1'b1;
                ctrl_rdata_i = r;
                resp_due = 0;
            end else begin
                ctrl_ready_i = ($urandom_range(0, 3) == 0);
                ctrl_rdata_i = $urandom;
            end
            if (cyc > 0 && v) begin
                resp_due  = 1;
                resp_addr = a;
            end
        end
        ctrl_ready_i = 1'b0;
        start_i = 1'b0;

        if (do_reset) begin
            chk("rst_trigger_seen", longint'(rst_hit), 1);
            n = polls + (CNT_EN ? 2 : 1);
            chk("rst_n_acc", longint'(obs_q.size()), longint'(n));
            for (int i = 0; i < obs_q.size() && i < n; i++)
                chk($sformatf("rst_acc%0d", i), longint'(obs_q[i]), longint'(exp_q[i]));
            return;
        end

        if (CNT_EN && !tmo) begin
            m_hit  = hv;
            m_miss = mv;
        end
        chk("n_acc", longint'(obs_q.size()), longint'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("acc%0d", i), longint'(obs_q[i]), longint'(exp_q[i]));
        chk("done_pulses", longint'(done_cnt), 1);
        chk("err", longint'(err_o), longint'(tmo));
        chk("hit_cnt", longint'(hit_cnt_o), longint'(m_hit));
        chk("miss_cnt", longint'(miss_cnt_o), longint'(m_miss));
        chk("addr_nonzero_idle", longint'(addr_bad), 0);
        chk("valid_twice", longint'(dbl), 0);
        chk("busy_after_done", longint'(busy_bad), 0);
    endtask

    initial begin
        reset_i      = 1'b1;
        start_i      = 1'b0;
        clr_cnt_i    = 1'b0;
        ctrl_ready_i = 1'b0;
        ctrl_rdata_i = '0;
        m_hit        = '0;
        m_miss       = '0;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        run_seq(1'b0, 0, 32'd5, 32'd2, 1'b0, 1'b1);
        run_seq(1'b0, 3, $urandom, $urandom, 1'b0, 1'b0);
        run_seq(1'b0, 9, $urandom, $urandom, 1'b0, 1'b1);
        run_seq(1'b1, 1, $urandom, $urandom, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            run_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), $urandom, $urandom,
                    1'b0, 1'($urandom_range(0, 1)));
        run_seq(1'b1, 1, $urandom, $urandom, 1'b1, 1'b0);
        run_seq(1'b1, 0, $urandom, $urandom, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
